mod_reduce_8_parts: RTL and testbench
=====================================

MOD_REDUCE_8_PARTS -- requirements
Module: mod_reduce_8_parts

Interface
REQ-001 SHALL have parameter SIZE, default 448: operand/modulus width, divisible by 8; chunk width W = SIZE/8.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to reduce x; sampled only in IDLE.
REQ-005 SHALL have port x  input  SIZE+1  unreduced value, e.g. a staged-adder sum; precondition x < 2p.
REQ-006 SHALL have port p  input  SIZE  modulus, nonzero.
REQ-007 SHALL have port result  output  SIZE  x mod p.
REQ-008 SHALL have port done  output  1  high when idle with result valid; low while busy.

Function
REQ-009 SHALL use states IDLE, STAGE1..STAGE8, encoded in 4 bits.
REQ-010 SHALL, in IDLE with start=1, compute {borrow, d0} = x[W-1:0] - p[W-1:0], clear done, go to STAGE1; with start=0, stay in IDLE and leave outputs unchanged.
REQ-011 SHALL, in STAGEk (k=1..7), compute {borrow, dk} = x chunk k - p chunk k - borrow, then go to STAGEk+1.
REQ-012 SHALL, in STAGE8, form final borrow nb = borrow AND NOT x[SIZE], which marks the full (SIZE+1)-bit difference x - p as negative.
REQ-013 SHALL, in STAGE8, write result = x[SIZE-1:0] if nb=1, else {d7..d0}; set done=1; go to IDLE.
REQ-014 SHALL assert done on the 8th rising edge after the edge that sampled start; fixed latency, data-independent.
REQ-015 SHALL ignore start in STAGE1..STAGE8, including the STAGE8 edge; the earliest new accept is the edge after done rises.
REQ-016 SHALL accept back-to-back operations with no dead cycle beyond the IDLE sampling cycle.
REQ-017 SHALL hold result and done stable in IDLE until the next accepted start.
REQ-018 SHALL give an unspecified, non-X result for x >= 2p, with unchanged timing.
REQ-019 SHALL give result = 0 for x = p and result = x for x < p.

Reset
REQ-020 SHALL, on rst=1, go to IDLE immediately, set done=1, result=0, borrow=0 and all partial chunks to 0.
REQ-021 SHALL abort an in-flight operation on mid-operation reset; no done pulse for it; start is accepted on the first edge after rst falls.

Configuration
REQ-022 SHALL honour macro MOD_REDUCE_INPUT_REG_EN.
REQ-023 SHALL, with MOD_REDUCE_INPUT_REG_EN defined, capture x and p into internal registers on the accepting edge and use only the captured copies in all stages; x and p may change from the next cycle on.
REQ-024 SHALL, without MOD_REDUCE_INPUT_REG_EN, read x and p directly from the ports in every stage; the producer SHALL hold them stable from the start edge through the STAGE8 edge. No extra registers; latency identical.

Verification
REQ-025 SHALL cover SIZE=448, p=2^448-2^224-1, x=5 -> result=5 after 8 edges, done low during edges 1..7.
REQ-026 SHALL cover x=p -> result=0; x=p+7 -> result=7; x=2p-1 -> result=p-1, which includes x[448]=1 with a long borrow chain.
REQ-027 SHALL cover x=2^56, p=2^56-1 (SIZE=448) -> result=1, borrow propagating from chunk 0 to chunk 1.
REQ-028 SHALL cover start held high continuously -> accepts exactly every 9 cycles; start pulse in STAGE3 and in STAGE8 -> ignored.
REQ-029 SHALL cover rst asserted in STAGE4 -> done=1, result=0 at once; new start with x=3 afterwards -> result=3 after 8 edges.
REQ-030 SHALL cover, with MOD_REDUCE_INPUT_REG_EN, x changed from p+7 to 0 one cycle after start -> result=7.

Source files
------------

// File: rtl/mod_reduce_8_parts.sv
// mod_reduce_8_parts: reduces x (< 2p) modulo p by one conditional subtraction of p,
// done as a W-bit-per-cycle borrow chain across 8 chunks (W = SIZE/8).
// Latency: done rises on the 8th rising edge after the edge that accepts start; data-independent.
// Backpressure: none; start is sampled only in IDLE and ignored while busy, including the STAGE8 edge.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   rst    - asynchronous active-high reset (IDLE, done=1, result=0)
//   start  - request to reduce x, sampled only in IDLE
//   x      - SIZE+1 bit unreduced value, expected < 2p
//   p      - SIZE bit nonzero modulus
//   result - x mod p, held stable in IDLE
//   done   - high when idle with result valid, low while busy
//
// Build option: define MOD_REDUCE_INPUT_REG_EN to capture x and p on the accepting
// edge so the producer may change them from the next cycle on. Without it, x and p
// are read from the ports in every stage and must be held stable by the producer.

module mod_reduce_8_parts #(
  parameter int SIZE = 448
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE:0]   x,
  input  logic [SIZE-1:0] p,
  output logic [SIZE-1:0] result,
  output logic            done
);

  localparam int W = SIZE / 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    STAGE1 = 4'd1,
    STAGE2 = 4'd2,
    STAGE3 = 4'd3,
    STAGE4 = 4'd4,
    STAGE5 = 4'd5,
    STAGE6 = 4'd6,
    STAGE7 = 4'd7,
    STAGE8 = 4'd8
  } state_t;

  state_t          state_q;
  logic            borrow_q;
  logic [SIZE-1:0] diff_q;      // {d7..d0}, the truncated x - p
  logic [SIZE-1:0] result_q;
  logic            done_q;

  logic [SIZE:0]   x_src;
  logic [SIZE-1:0] p_src;

`ifdef MOD_REDUCE_INPUT_REG_EN
  logic [SIZE:0]   x_q;
  logic [SIZE-1:0] p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      p_q <= '0;
    end else if (state_q == IDLE && start) begin
      x_q <= x;
      p_q <= p;
    end
  end

  // The accepting cycle works on the ports (chunk 0); every stage after uses the copies.
  assign x_src = (state_q == IDLE) ? x : x_q;
  assign p_src = (state_q == IDLE) ? p : p_q;
`else
  assign x_src = x;
  assign p_src = p;
`endif

  // Chunk k is processed while in STAGEk; IDLE (encoding 0) naturally selects chunk 0.
  logic [2:0]   chunk_idx;
  logic         borrow_in;
  logic [W-1:0] x_chunk;
  logic [W-1:0] p_chunk;
  logic [W:0]   diff_d;       // MSB is the borrow out of this chunk
  logic         nb;

  always_comb begin
    chunk_idx = state_q[2:0];
    borrow_in = (state_q == IDLE) ? 1'b0 : borrow_q;
    x_chunk   = x_src[int'(chunk_idx) * W +: W];
    p_chunk   = p_src[int'(chunk_idx) * W +: W];
    diff_d    = {1'b0, x_chunk} - {1'b0, p_chunk} - {{W{1'b0}}, borrow_in};
    // x[SIZE] set absorbs the borrow out of the low SIZE bits: x - p is then non-negative.
    nb        = borrow_q & ~x_src[SIZE];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            diff_q[W-1:0] <= diff_d[W-1:0];
            borrow_q      <= diff_d[W];
            done_q        <= 1'b0;
            state_q       <= STAGE1;
          end
        end
        STAGE1, STAGE2, STAGE3, STAGE4, STAGE5, STAGE6, STAGE7: begin
          diff_q[int'(chunk_idx) * W +: W] <= diff_d[W-1:0];
          borrow_q                         <= diff_d[W];
          state_q                          <= state_t'(state_q + 4'd1);
        end
        STAGE8: begin
          result_q <= nb ? x_src[SIZE-1:0] : diff_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mod_reduce_8_parts.sv
// tb_mod_reduce_8_parts: randomized and directed checks of mod_reduce_8_parts
// against a plain-arithmetic x mod p reference.
// Inputs driven on the falling edge, outputs sampled on the falling edge.

module tb_mod_reduce_8_parts;

  localparam int SIZE = 448;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE:0]   x;
  logic [SIZE-1:0] p;
  logic [SIZE-1:0] result;
  logic            done;

  int checks   = 0;
  int failures = 0;

  localparam logic [SIZE:0] ONE  = 1;
  localparam logic [SIZE:0] ZERO = 0;

  always #5 clk = ~clk;

  mod_reduce_8_parts #(.SIZE(SIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .p      (p),
    .result (result),
    .done   (done)
  );

  task automatic check(input string tag, input logic [SIZE:0] got, input logic [SIZE:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the value x mod p, straight from the definition.
  function automatic logic [SIZE:0] ref_mod(input logic [SIZE:0] xv, input logic [SIZE-1:0] pv);
    logic [SIZE:0] pw;
    pw = {1'b0, pv};
    return xv % pw;
  endfunction

  function automatic logic [SIZE:0] rand_wide();
    logic [479:0] t;
    for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom();
    return t[SIZE:0];
  endfunction

  function automatic logic [SIZE-1:0] rand_p();
    logic [SIZE:0] r;
    logic [SIZE-1:0] pv;
    r  = rand_wide();
    pv = r[SIZE-1:0] >> $urandom_range(0, 200);
    if (pv == '0) pv = 1;
    return pv;
  endfunction

  function automatic logic [SIZE:0] rand_x(input logic [SIZE-1:0] pv);
    logic [SIZE:0] two_p;
    two_p = {pv, 1'b0};
    return rand_wide() % two_p;
  endfunction

  // One full operation; pulse_after=k raises start for one cycle while in STAGE(k+1).
  task automatic run_op(input logic [SIZE:0] xv, input logic [SIZE-1:0] pv,
                        input int pulse_after, input string tag);
    logic [SIZE:0] exp;
    exp = ref_mod(xv, pv);
    @(negedge clk);
    x = xv;
    p = pv;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = (i == pulse_after);
      check({tag, "_busy"}, (SIZE+1)'(done), ZERO);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, (SIZE+1)'(done), ONE);
    check({tag, "_result"}, (SIZE+1)'(result), exp);
    if (pulse_after >= 0) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_done"}, (SIZE+1)'(done), ONE);
      check({tag, "_hold_result"}, (SIZE+1)'(result), exp);
    end
  endtask

  logic [SIZE:0]   big_p_w;
  logic [SIZE-1:0] big_p;
  logic [SIZE:0]   xr;
  logic [SIZE:0]   exp_c;
  logic [SIZE-1:0] pr;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    p     = 1;
    big_p_w = (ONE << 448) - (ONE << 224) - ONE;
    big_p   = big_p_w[SIZE-1:0];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_done", (SIZE+1)'(done), ONE);
    check("reset_result", (SIZE+1)'(result), ZERO);
    rst = 1'b0;

    // Directed values
    run_op(449'd5, big_p, -1, "x5");
    run_op({1'b0, big_p}, big_p, -1, "x_eq_p");
    run_op({1'b0, big_p} + 449'd7, big_p, -1, "x_p7");
    run_op({big_p, 1'b0} - ONE, big_p, -1, "x_2p_m1");
    run_op(ONE << 56, (SIZE)'((ONE << 56) - ONE), -1, "chunk_borrow");

    // start pulses while busy must be ignored
    run_op(rand_x(big_p), big_p, 2, "pulse_stage3");
    run_op(rand_x(big_p), big_p, 7, "pulse_stage8");

    // Random operands
    for (int n = 0; n < 20; n++) begin
      pr = rand_p();
      run_op(rand_x(pr), pr, -1, "rand");
    end

    // start held high: one accept every 9 cycles, done high on every 9th
    pr = rand_p();
    xr = rand_x(pr);
    @(negedge clk);
    x = xr;
    p = pr;
    start = 1'b1;
    exp_c = ref_mod(xr, pr);
    for (int n = 0; n < 27; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("cont_done", (SIZE+1)'(done), ((n % 9) == 8) ? ONE : ZERO);
      if ((n % 9) == 8) begin
        check("cont_result", (SIZE+1)'(result), exp_c);
        xr = rand_x(pr);
        x = xr;
        exp_c = ref_mod(xr, pr);
      end
    end
    start = 1'b0;

    // Reset in STAGE4 aborts the operation
    @(negedge clk);
    x = {1'b0, big_p} + 449'd7;
    p = big_p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_done", (SIZE+1)'(done), ONE);
    check("midrst_result", (SIZE+1)'(result), ZERO);
    @(negedge clk);
    rst = 1'b0;
    run_op(449'd3, big_p, -1, "after_rst");

`ifdef MOD_REDUCE_INPUT_REG_EN
    // Captured inputs: operands may change right after the accepting edge
    @(negedge clk);
    x = {1'b0, big_p} + 449'd7;
    p = big_p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("inreg_done", (SIZE+1)'(done), ONE);
    check("inreg_result", (SIZE+1)'(result), 449'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
